// File: rtl/logic_unit_pkg.sv
// Shared operation encoding and per-bit operator for the logic unit pipeline.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT_A  = 3'd0,
    OP_AND    = 3'd1,
    OP_OR     = 3'd2,
    OP_XOR    = 3'd3,
    OP_NAND   = 3'd4,
    OP_NOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  function automatic logic bit_op(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_NOT_A:  r = ~a;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_alu.sv
// Purely combinational bitwise operator; each result bit depends only on the
// same bit of a and b, so there is no carry or sign behaviour.
module logic_unit_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign result[gi] = bit_op(op_e'(op), a[gi], b[gi]);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with saturating completion counter.
// Define LOGIC_UNIT_PARITY_EN to add the registered y_parity output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             y_parity
`endif
);

  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] s1_data_reg;
  logic [WIDTH-1:0] s2_data_reg;
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             s1_load;
  logic             s2_load;
  logic             in_fire;
  logic             out_fire;

  logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_result)
  );

  // Load enables depend only on stage valids and out_ready, never on in_valid.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;
  assign out_fire = s2_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      if (s1_load) s1_valid_reg <= in_valid;
      if (in_fire) s1_data_reg  <= alu_result;
    end
  end

  // S2 data only changes when a real beat moves in, so y keeps the last
  // accepted result while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      if (s2_load)                 s2_valid_reg <= s1_valid_reg;
      if (s2_load && s1_valid_reg) s2_data_reg  <= s1_data_reg;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (out_fire && (cnt_reg != {CNT_W{1'b1}})) cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign out_valid = s2_valid_reg;
  assign y         = s2_data_reg;
  assign txn_count = cnt_reg;

`ifdef LOGIC_UNIT_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       parity_reg <= 1'b0;
    else if (s2_load && s1_valid_reg) parity_reg <= ^s1_data_reg;
  end

  assign y_parity = parity_reg;
`endif

endmodule
